// File: rtl/fp_addsub_pipe_if.sv
// Operand/result handshake bundle for the pipelined IEEE-754 adder/subtractor.
// slave is the adder side, master is the operand source / result sink side.
interface fp_addsub_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         i_valid;
  logic         o_ready;
  logic         i_op;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_res;
  logic [3:0]   o_flags;

  modport master (
    output i_valid, i_op, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_res, o_flags
  );

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_ready,
    output o_ready, o_valid, o_res, o_flags
  );
endinterface

// File: rtl/fp_addsub_pipe.sv
// 3-stage pipelined IEEE-754 add/sub: unpack/align, add, normalise/round.
// Round-to-nearest-even, subnormal results flushed to signed zero.
module fp_addsub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  fp_addsub_pipe_if.slave bus
);
  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned DW  = MAN_W + 4;          // hidden + fraction + G/R/S
  localparam int unsigned SW  = MAN_W + 5;          // DW plus carry-out
  localparam int unsigned EW  = EXP_W + 1;
  localparam int unsigned LZW = $clog2(DW + 1);

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EW-1:0]    EXP_MAX  = EW'(EXP_ONES);
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [LZW-1:0] lzc(input logic [DW-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + LZW'(1);
      end
    end
    return n;
  endfunction

  // Pipeline state
  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q, s1_sign_d;
  logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
  logic [DW-1:0]    s1_man_l_q, s1_man_l_d;
  logic [DW-1:0]    s1_man_s_q, s1_man_s_d;
  logic             s1_sub_q, s1_sub_d;
  logic             s1_nan_q, s1_nan_d;
  logic             s1_inf_q, s1_inf_d;
  logic             s1_inf_sign_q, s1_inf_sign_d;

  logic             s2_valid_q, s2_valid_d;
  logic             s2_sign_q, s2_sign_d;
  logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
  logic [SW-1:0]    s2_sum_q, s2_sum_d;
  logic             s2_sub_q, s2_sub_d;
  logic             s2_nan_q, s2_nan_d;
  logic             s2_inf_q, s2_inf_d;
  logic             s2_inf_sign_q, s2_inf_sign_d;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_res_q, out_res_d;
  logic [3:0]       out_flags_q, out_flags_d;

  logic             advance;

  // Stage 1 temporaries
  logic             a_sign, b_sign, a_nan, b_nan, a_inf, b_inf, a_ge;
  logic [EXP_W-1:0] a_exp, b_exp, l_exp, s_exp, l_eexp, s_eexp, diff;
  logic [MAN_W-1:0] a_frac, b_frac, l_frac, s_frac;
  logic [MAN_W:0]   l_man, s_man;
  logic [2*DW-1:0]  wide;
  logic [DW-1:0]    s_align;

  // Stage 3 temporaries
  logic             carry, uflow, rnd_inc, inexact;
  logic [DW-1:0]    m0, m;
  logic [LZW-1:0]   lz;
  logic [EW-1:0]    e, e_r;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac;

  assign advance     = !out_valid_q || bus.i_ready;
  assign bus.o_ready = advance;
  assign bus.o_valid = out_valid_q;
  assign bus.o_res   = out_res_q;
  assign bus.o_flags = out_flags_q;

  always_comb begin
    s1_valid_d = s1_valid_q;   s1_sign_d = s1_sign_q;   s1_exp_d = s1_exp_q;
    s1_man_l_d = s1_man_l_q;   s1_man_s_d = s1_man_s_q; s1_sub_d = s1_sub_q;
    s1_nan_d = s1_nan_q;       s1_inf_d = s1_inf_q;     s1_inf_sign_d = s1_inf_sign_q;
    s2_valid_d = s2_valid_q;   s2_sign_d = s2_sign_q;   s2_exp_d = s2_exp_q;
    s2_sum_d = s2_sum_q;       s2_sub_d = s2_sub_q;     s2_nan_d = s2_nan_q;
    s2_inf_d = s2_inf_q;       s2_inf_sign_d = s2_inf_sign_q;
    out_valid_d = out_valid_q; out_res_d = out_res_q;   out_flags_d = out_flags_q;

    // Stage 1: unpack, order by magnitude, align the smaller operand
    a_sign = bus.i_a[W-1];
    a_exp  = bus.i_a[W-2 -: EXP_W];
    a_frac = bus.i_a[MAN_W-1:0];
    b_sign = bus.i_b[W-1] ^ bus.i_op;
    b_exp  = bus.i_b[W-2 -: EXP_W];
    b_frac = bus.i_b[MAN_W-1:0];
    a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
    b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
    a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
    b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
    a_ge   = {a_exp, a_frac} >= {b_exp, b_frac};
    l_exp  = a_ge ? a_exp  : b_exp;
    s_exp  = a_ge ? b_exp  : a_exp;
    l_frac = a_ge ? a_frac : b_frac;
    s_frac = a_ge ? b_frac : a_frac;
    l_eexp = (l_exp == '0) ? EXP_W'(1) : l_exp;
    s_eexp = (s_exp == '0) ? EXP_W'(1) : s_exp;
    l_man  = {l_exp != '0, l_frac};
    s_man  = {s_exp != '0, s_frac};
    diff   = l_eexp - s_eexp;
    wide   = '0;
    if (32'(diff) >= MAN_W + 3) begin
      s_align = {{(DW-1){1'b0}}, |s_man};
    end else begin
      wide    = {s_man, 3'b000, {DW{1'b0}}} >> diff;
      s_align = wide[2*DW-1:DW] | {{(DW-1){1'b0}}, |wide[DW-1:0]};
    end

    // Stage 3: normalise, round, pack
    carry = s2_sum_q[SW-1];
    m0    = s2_sum_q[DW-1:0];
    lz    = lzc(m0);
    uflow = 1'b0;
    m     = m0;
    e     = EW'(s2_exp_q);
    if (carry) begin
      m = {s2_sum_q[SW-1:2], s2_sum_q[1] | s2_sum_q[0]};
      e = EW'(s2_exp_q) + EW'(1);
    end else begin
      m = m0 << lz;
      if (EW'(lz) >= EW'(s2_exp_q)) uflow = 1'b1;
      else                          e = EW'(s2_exp_q) - EW'(lz);
    end
    rnd_inc = m[2] & (m[1] | m[0] | m[3]);
    inexact = |m[2:0];
    mant_r  = {1'b0, m[DW-1:3]} + (MAN_W+2)'(rnd_inc);
    if (mant_r[MAN_W+1]) begin
      frac = mant_r[MAN_W:1];
      e_r  = e + EW'(1);
    end else begin
      frac = mant_r[MAN_W-1:0];
      e_r  = e;
    end

    if (advance) begin
      s1_valid_d    = bus.i_valid;
      s1_sign_d     = a_ge ? a_sign : b_sign;
      s1_exp_d      = l_eexp;
      s1_man_l_d    = {l_man, 3'b000};
      s1_man_s_d    = s_align;
      s1_sub_d      = a_sign ^ b_sign;
      s1_nan_d      = a_nan | b_nan | (a_inf & b_inf & (a_sign ^ b_sign));
      s1_inf_d      = a_inf | b_inf;
      s1_inf_sign_d = a_inf ? a_sign : b_sign;

      s2_valid_d    = s1_valid_q;
      s2_sign_d     = s1_sign_q;
      s2_exp_d      = s1_exp_q;
      s2_sum_d      = s1_sub_q ? ({1'b0, s1_man_l_q} - {1'b0, s1_man_s_q})
                               : ({1'b0, s1_man_l_q} + {1'b0, s1_man_s_q});
      s2_sub_d      = s1_sub_q;
      s2_nan_d      = s1_nan_q;
      s2_inf_d      = s1_inf_q;
      s2_inf_sign_d = s1_inf_sign_q;

      out_valid_d   = s2_valid_q;
      if (s2_valid_q) begin
        if (s2_nan_q) begin
          out_res_d   = QNAN;
          out_flags_d = 4'b1000;
        end else if (s2_inf_q) begin
          out_res_d   = {s2_inf_sign_q, EXP_ONES, {MAN_W{1'b0}}};
          out_flags_d = 4'b0000;
        end else if (s2_sum_q == '0) begin
          // Exact cancellation is +0; like-signed zeros keep their sign
          out_res_d   = {s2_sign_q & ~s2_sub_q, {(W-1){1'b0}}};
          out_flags_d = 4'b0000;
        end else if (uflow) begin
          out_res_d   = {s2_sign_q, {(W-1){1'b0}}};
          out_flags_d = 4'b0011;
        end else if (e_r >= EXP_MAX) begin
          out_res_d   = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
          out_flags_d = 4'b0101;
        end else begin
          out_res_d   = {s2_sign_q, e_r[EXP_W-1:0], frac};
          out_flags_d = {3'b000, inexact};
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0; s1_sign_q <= 1'b0; s1_exp_q <= '0; s1_man_l_q <= '0;
      s1_man_s_q <= '0;   s1_sub_q <= 1'b0;  s1_nan_q <= 1'b0; s1_inf_q <= 1'b0;
      s1_inf_sign_q <= 1'b0;
      s2_valid_q <= 1'b0; s2_sign_q <= 1'b0; s2_exp_q <= '0; s2_sum_q <= '0;
      s2_sub_q <= 1'b0;   s2_nan_q <= 1'b0;  s2_inf_q <= 1'b0; s2_inf_sign_q <= 1'b0;
      out_valid_q <= 1'b0; out_res_q <= '0; out_flags_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d; s1_sign_q <= s1_sign_d; s1_exp_q <= s1_exp_d;
      s1_man_l_q <= s1_man_l_d; s1_man_s_q <= s1_man_s_d; s1_sub_q <= s1_sub_d;
      s1_nan_q <= s1_nan_d;     s1_inf_q <= s1_inf_d;     s1_inf_sign_q <= s1_inf_sign_d;
      s2_valid_q <= s2_valid_d; s2_sign_q <= s2_sign_d; s2_exp_q <= s2_exp_d;
      s2_sum_q <= s2_sum_d;     s2_sub_q <= s2_sub_d;   s2_nan_q <= s2_nan_d;
      s2_inf_q <= s2_inf_d;     s2_inf_sign_q <= s2_inf_sign_d;
      out_valid_q <= out_valid_d; out_res_q <= out_res_d; out_flags_q <= out_flags_d;
    end
  end
endmodule
